// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the integer clock divider controller.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } clkdiv_state_t;

    localparam int CLKDIV_MIN_DIV = 2;

    // Divisors below the minimum would give a period with no low phase.
    function automatic logic [15:0] clkdiv_clamp(input logic [15:0] div);
        return (div < 16'(CLKDIV_MIN_DIV)) ? 16'(CLKDIV_MIN_DIV) : div;
    endfunction

endpackage

// File: rtl/clkdiv_if.sv
// Run request, divisor handshake and divided-clock outputs of clkdiv_ctrl.
interface clkdiv_if #(
    parameter int CW = 8
);
    logic          en;
    logic          cfg_valid;
    logic [CW-1:0] cfg_div;
    logic          cfg_ready;
    logic          clkout;
    logic          tick;
    logic          busy;
    logic [CW-1:0] cur_div;

    modport master (
        output en, cfg_valid, cfg_div,
        input  cfg_ready, clkout, tick, busy, cur_div
    );

    modport slave (
        input  en, cfg_valid, cfg_div,
        output cfg_ready, clkout, tick, busy, cur_div
    );
endinterface

// File: rtl/clkdiv_core.sv
// Period counter and output flops; run/div are next-cycle values so clkout
// and tick come straight from flops.
module clkdiv_core
    import clkdiv_pkg::*;
#(
    parameter int CW      = 8,
    parameter int DEF_DIV = 3
) (
    input  logic          clkin,
    input  logic          reset,
    input  logic          run,
    input  logic [CW-1:0] div,
    output logic          boundary,
    output logic          clkout,
    output logic          tick,
    output logic [CW-1:0] cur_div
);
    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_div;
    logic          r_clkout;
    logic          r_tick;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW:0]   w_high;

    always_comb begin
        boundary  = r_active && (r_cnt == (r_div - CW'(1)));
        w_high    = ({1'b0, div} + (CW+1)'(1)) >> 1;
        w_cnt_nxt = '0;
        // A period entered from idle starts at 0 rather than incrementing.
        if (run && r_active && !boundary) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_div    <= CW'(DEF_DIV);
            r_clkout <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_active <= run;
            r_cnt    <= w_cnt_nxt;
            r_div    <= div;
            r_clkout <= run && ({1'b0, w_cnt_nxt} < w_high);
            r_tick   <= run && (w_cnt_nxt == '0);
        end
    end

    assign clkout  = r_clkout;
    assign tick    = r_tick;
    assign cur_div = r_div;
endmodule

// File: rtl/clkdiv_ctrl.sv
// Run/stop FSM and pending-divisor register around clkdiv_core.
//   state   | meaning
//   ST_IDLE | stopped, clkout low, counter held at 0
//   ST_RUN  | dividing, en still requested
//   ST_STOP | en dropped, finishing the current period
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int CW      = 8,
    parameter int DEF_DIV = 3
) (
    input  logic     clkin,
    input  logic     reset,
    clkdiv_if.slave  bus
);
    clkdiv_state_t r_state;
    clkdiv_state_t w_state_nxt;
    logic          r_pend_v;
    logic [CW-1:0] r_pend_div;
    logic [CW-1:0] w_div_clamp;
    logic [CW-1:0] w_div_nxt;
    logic          w_accept;
    logic          w_boundary;
    logic          w_run_nxt;

    assign w_div_clamp = CW'(clkdiv_clamp(16'(bus.cfg_div)));
    assign w_accept    = bus.cfg_valid && !r_pend_v;

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = bus.cur_div;
        unique case (r_state)
            ST_IDLE: if (bus.en) w_state_nxt = ST_RUN;
            ST_RUN:  if (!bus.en) w_state_nxt = ST_STOP;
            ST_STOP: begin
                if (bus.en) w_state_nxt = ST_RUN;
                else if (w_boundary) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (r_pend_v && w_boundary) begin
            w_div_nxt = r_pend_div;
        end else if (w_accept && (r_state == ST_IDLE)) begin
            w_div_nxt = w_div_clamp;
        end
        w_run_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pend_v   <= 1'b0;
            r_pend_div <= '0;
        end else begin
            r_state <= w_state_nxt;
            // An acceptance in the boundary cycle cannot clear here since pend_v was 0.
            if (r_pend_v && w_boundary) begin
                r_pend_v <= 1'b0;
            end else if (w_accept && (r_state != ST_IDLE)) begin
                r_pend_v   <= 1'b1;
                r_pend_div <= w_div_clamp;
            end
        end
    end

    clkdiv_core #(
        .CW      (CW),
        .DEF_DIV (DEF_DIV)
    ) u_core (
        .clkin    (clkin),
        .reset    (reset),
        .run      (w_run_nxt),
        .div      (w_div_nxt),
        .boundary (w_boundary),
        .clkout   (bus.clkout),
        .tick     (bus.tick),
        .cur_div  (bus.cur_div)
    );

    assign bus.cfg_ready = !r_pend_v;
    assign bus.busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Bench for clkdiv_ctrl: vector table, directed corner sequences and random
// stimulus against a cycle-level reference model of the divider rules.
module tb_clkdiv_ctrl;
    logic clkin = 1'b0;
    logic rst;
    always #5 clkin = ~clkin;

    clkdiv_if #(.CW(8)) bus();

    clkdiv_ctrl #(.CW(8), .DEF_DIV(3)) dut (
        .clkin (clkin),
        .reset (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model: mode 0 idle, 1 run, 2 stop
    int m_mode, m_cnt, m_div, m_pv, m_pd;
    bit m_acc;

    typedef struct {
        bit en; bit cv; int cd;
        int clk; int tick; int busy; int rdy; int cur;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit e, input bit cv, input int cd);
        bit bnd;
        int nmode;
        int cl;
        cl    = (cd < 2) ? 2 : cd;
        m_acc = 1'b0;
        if (r) begin
            m_mode = 0; m_cnt = 0; m_div = 3; m_pv = 0; m_pd = 0;
            return;
        end
        bnd   = (m_mode != 0) && (m_cnt == m_div - 1);
        m_acc = cv && (m_pv == 0);
        case (m_mode)
            0:       nmode = e ? 1 : 0;
            1:       nmode = e ? 1 : 2;
            default: nmode = e ? 1 : (bnd ? 0 : 2);
        endcase
        if (nmode == 0 || m_mode == 0 || bnd) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        if (m_pv != 0 && bnd) begin
            m_div = m_pd;
            m_pv  = 0;
        end else if (m_acc) begin
            if (m_mode == 0) m_div = cl;
            else begin
                m_pv = 1;
                m_pd = cl;
            end
        end
        m_mode = nmode;
    endtask

    task automatic step(input bit e, input bit cv, input int cd, input bit r);
        @(negedge clkin);
        rst           = r;
        bus.en        = e;
        bus.cfg_valid = cv;
        bus.cfg_div   = 8'(cd);
        @(posedge clkin);
        model_update(r, e, cv, cd);
        #1;
    endtask

    task automatic cmp_model();
        chk("clkout",    bus.clkout,    (m_mode != 0 && m_cnt < (m_div + 1) / 2) ? 1 : 0);
        chk("tick",      bus.tick,      (m_mode != 0 && m_cnt == 0) ? 1 : 0);
        chk("busy",      bus.busy,      (m_mode != 0) ? 1 : 0);
        chk("cfg_ready", bus.cfg_ready, (m_pv == 0) ? 1 : 0);
        chk("cur_div",   bus.cur_div,   m_div);
    endtask

    task automatic cyc(input bit e, input bit cv, input int cd);
        step(e, cv, cd, 1'b0);
        cmp_model();
    endtask

    task automatic cyc_rst();
        step(1'b0, 1'b0, 0, 1'b1);
        cmp_model();
    endtask

    initial begin
        int exp_a[11];
        int exp_b[6];
        int n;
        bit e;
        bit hold;
        bit cv;
        bit r;
        int cd;

        rst = 1'b1; bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_div = '0;
        exp_a = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
        exp_b = '{1, 1, 1, 0, 0, 0};

        //            en cv cd  clk tick busy rdy cur
        tbl[0]  = '{1, 0, 0,  1, 1, 1, 1, 3};
        tbl[1]  = '{1, 0, 0,  1, 0, 1, 1, 3};
        tbl[2]  = '{1, 0, 0,  0, 0, 1, 1, 3};
        tbl[3]  = '{1, 0, 0,  1, 1, 1, 1, 3};
        tbl[4]  = '{1, 0, 0,  1, 0, 1, 1, 3};
        tbl[5]  = '{0, 0, 0,  0, 0, 1, 1, 3};
        tbl[6]  = '{0, 0, 0,  0, 0, 0, 1, 3};
        tbl[7]  = '{0, 1, 1,  0, 0, 0, 1, 2};
        tbl[8]  = '{1, 0, 0,  1, 1, 1, 1, 2};
        tbl[9]  = '{0, 0, 0,  0, 0, 1, 1, 2};
        tbl[10] = '{0, 0, 0,  0, 0, 0, 1, 2};

        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);
        chk("rst_clkout", bus.clkout, 0);
        chk("rst_tick",   bus.tick, 0);
        chk("rst_busy",   bus.busy, 0);
        chk("rst_ready",  bus.cfg_ready, 1);
        chk("rst_cur",    bus.cur_div, 3);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].en, tbl[i].cv, tbl[i].cd, 1'b0);
            chk($sformatf("tbl%0d_clkout", i), bus.clkout, tbl[i].clk);
            chk($sformatf("tbl%0d_tick", i),   bus.tick, tbl[i].tick);
            chk($sformatf("tbl%0d_busy", i),   bus.busy, tbl[i].busy);
            chk($sformatf("tbl%0d_ready", i),  bus.cfg_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_cur", i),    bus.cur_div, tbl[i].cur);
        end

        // divisor change 4 -> 5 requested mid-period
        cyc_rst();
        cyc(1'b0, 1'b1, 4);
        cyc(1'b1, 1'b0, 0);
        cyc(1'b1, 1'b0, 0);
        cyc(1'b1, 1'b1, 5);
        chk("a_ready_drop", bus.cfg_ready, 0);
        for (int k = 0; k < 11; k++) begin
            cyc(1'b1, 1'b0, 0);
            chk($sformatf("a_clk%0d", k), bus.clkout, exp_a[k]);
        end
        chk("a_cur_div", bus.cur_div, 5);
        chk("a_ready_back", bus.cfg_ready, 1);

        // stop at N=6 completes the period, then a stop/restart without glitch
        cyc_rst();
        cyc(1'b0, 1'b1, 6);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 0);
        chk("b_busy_last", bus.busy, 1);
        cyc(1'b0, 1'b0, 0);
        chk("b_busy_after", bus.busy, 0);
        chk("b_clk_after", bus.clkout, 0);
        cyc(1'b1, 1'b0, 0);
        cyc(1'b1, 1'b0, 0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 0);
        chk("b_resume_busy", bus.busy, 1);
        chk("b_resume_clk", bus.clkout, 0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0, 0);
            chk($sformatf("b_clk%0d", k), bus.clkout, exp_b[k]);
        end

        // acceptance in the boundary cycle, then a stalled second request
        cyc_rst();
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 0);
        cyc(1'b1, 1'b1, 4);
        chk("c_ready_drop", bus.cfg_ready, 0);
        chk("c_cur_held", bus.cur_div, 3);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.cfg_ready == 1'b1) begin
                cyc(1'b1, 1'b1, 7);
                break;
            end
            cyc(1'b1, 1'b1, 7);
            n++;
        end
        chk("c_stall_cycles", n, 3);
        chk("c_cur_mid", bus.cur_div, 4);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 0);
        chk("c_cur_new", bus.cur_div, 7);

        // reset mid-period at N=7
        cyc_rst();
        cyc(1'b0, 1'b1, 7);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0, 1'b1);
        chk("d_clkout", bus.clkout, 0);
        chk("d_tick",   bus.tick, 0);
        chk("d_busy",   bus.busy, 0);
        chk("d_ready",  bus.cfg_ready, 1);
        chk("d_cur",    bus.cur_div, 3);

        e = 1'b0; hold = 1'b0; cv = 1'b0; cd = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 15) == 0) e = !e;
            if (!hold) begin
                cv = ($urandom_range(0, 3) == 0);
                cd = $urandom_range(0, 12);
            end
            step(e, cv, cd, r);
            cmp_model();
            hold = cv && !m_acc && !r;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
